// File: rtl/servo_pkg.sv
// Shared constants for the servo PWM generator/capture pair.
// The same defaults feed the position generator so both ends stay matched.
package servo_pkg;

    localparam int unsigned CLK_HZ         = 50_000_000;

    localparam int unsigned DEF_PULSE_MIN  = 50_000;     // 1.0 ms -> POS 0
    localparam int unsigned DEF_PULSE_MAX  = 100_000;    // 2.0 ms -> POS_MAX
    localparam int unsigned DEF_STEP       = 278;        // cycles per POS unit
    localparam int unsigned DEF_POS_MAX    = 180;
    localparam int unsigned DEF_PERIOD_MIN = 900_000;    // 18 ms
    localparam int unsigned DEF_PERIOD_MAX = 1_100_000;  // 22 ms

    localparam int unsigned W_BITS = 17;  // high-time counter / dividend width
    localparam int unsigned P_BITS = 21;  // period counter width

    typedef enum logic [1:0] {
        SYNC      = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2,
        LOW       = 2'd3
    } cap_state_t;

    // Saturate a divider quotient to the position range.
    function automatic logic [7:0] clamp_pos(input logic [W_BITS-1:0] q,
                                             input logic [7:0]        lim);
        return (q > {{(W_BITS-8){1'b0}}, lim}) ? lim : q[7:0];
    endfunction

endpackage

// File: rtl/servo_pos_divider.sv
// Restoring divider: fixed divisor, 17-bit dividend, one quotient bit per cycle.
// done is asserted during the 17th iteration cycle with the final quotient on
// quotient, so a caller registering on done sees the result one cycle later.
// A start while busy reloads the operands and abandons the running division.
module servo_pos_divider
    import servo_pkg::*;
#(
    parameter int unsigned DIVISOR = DEF_STEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W_BITS-1:0] dividend,
    output logic              busy,
    output logic              done,
    output logic [W_BITS-1:0] quotient
);

    localparam logic [W_BITS:0]   DIV_WIDE = (W_BITS+1)'(DIVISOR);
    localparam logic [W_BITS-1:0] DIV_NARROW = W_BITS'(DIVISOR);

    logic [W_BITS-1:0] rem_q;
    logic [W_BITS-1:0] quo_q;
    logic [4:0]        cnt_q;

    logic [W_BITS:0]   rem_sh;
    logic [W_BITS-1:0] diff;
    logic              ge;

    // One restoring step: shift in the next dividend bit, trial-subtract.
    // The remainder after a successful subtract is below the divisor, so the
    // low bits of the subtraction are exact.
    always_comb begin
        rem_sh   = {rem_q, quo_q[W_BITS-1]};
        ge       = (rem_sh >= DIV_WIDE);
        diff     = rem_sh[W_BITS-1:0] - DIV_NARROW;
        quotient = {quo_q[W_BITS-2:0], ge};
        busy     = (cnt_q != 5'd0);
        done     = (cnt_q == 5'd1);
    end

    // Iteration state: load on start, then one step per cycle until cnt hits 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            cnt_q <= 5'(W_BITS);
        end else if (busy) begin
            rem_q <= ge ? diff : rem_sh[W_BITS-1:0];
            quo_q <= quotient;
            cnt_q <= cnt_q - 5'd1;
        end
    end

endmodule

// File: rtl/servo_pwm_capture.sv
// Servo PWM capture: measures high time and rise-to-rise period of one servo
// input and recovers the position code that produced it.
// Optional feature macro: PWM_TIMEOUT_EN -- a period counter reaching
// PERIOD_MAX while tracking raises signal_lost and resynchronises the FSM.
module servo_pwm_capture
    import servo_pkg::*;
#(
    parameter int unsigned PULSE_MIN  = DEF_PULSE_MIN,
    parameter int unsigned PULSE_MAX  = DEF_PULSE_MAX,
    parameter int unsigned STEP       = DEF_STEP,
    parameter int unsigned POS_MAX    = DEF_POS_MAX,
    parameter int unsigned PERIOD_MIN = DEF_PERIOD_MIN,
    parameter int unsigned PERIOD_MAX = DEF_PERIOD_MAX
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PWM_in,
    output logic [7:0]        POS,
    output logic              POS_valid,
    output logic [W_BITS-1:0] width,
    output logic              err_range,
    output logic              err_period,
    output logic              signal_lost
);

    localparam logic [W_BITS-1:0] W_MIN   = W_BITS'(PULSE_MIN);
    localparam logic [W_BITS-1:0] W_MAX   = W_BITS'(PULSE_MAX);
    localparam logic [W_BITS-1:0] W_SAT   = '1;
    localparam logic [P_BITS-1:0] P_SAT   = '1;
    // pcnt is cleared on the rise, so at the next rise it holds period-1.
    localparam logic [P_BITS-1:0] P_LO    = P_BITS'(PERIOD_MIN - 1);
    localparam logic [P_BITS-1:0] P_MAX   = P_BITS'(PERIOD_MAX);
    localparam logic [7:0]        POS_LIM = 8'(POS_MAX);

    // ---------------- input conditioning ----------------
    logic pwm_s1, pwm_s2, pwm_d;
    logic rise, fall;

    // Synchroniser and edge flop run through reset so that SYNC sees the true
    // pin level immediately after reset is released.
    always_ff @(posedge CLK) begin
        pwm_s1 <= PWM_in;
        pwm_s2 <= pwm_s1;
        pwm_d  <= pwm_s2;
    end

    assign rise = pwm_s2 & ~pwm_d;
    assign fall = ~pwm_s2 & pwm_d;

    // ---------------- counters ----------------
    logic [W_BITS-1:0] hcnt;
    logic [P_BITS-1:0] pcnt;
    logic              timeout;

`ifdef PWM_TIMEOUT_EN
    assign timeout = (pcnt >= P_MAX);
`else
    assign timeout = 1'b0;
`endif

    // ---------------- FSM ----------------
    cap_state_t state, state_nxt;
    logic hcnt_clr, hcnt_run, meas_done, prd_chk;
`ifdef PWM_TIMEOUT_EN
    logic lost_set, lost_clr;
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= SYNC;
        else     state <= state_nxt;
    end

    // Next state: SYNC waits for the pin low so a pulse in progress is skipped.
    always_comb begin
        state_nxt = state;
        case (state)
            SYNC:      if (!pwm_s2) state_nxt = WAIT_RISE;
            WAIT_RISE: if (rise)    state_nxt = HIGH;
            HIGH: begin
                if (timeout)   state_nxt = SYNC;
                else if (fall) state_nxt = LOW;
            end
            LOW: begin
                if (timeout)   state_nxt = SYNC;
                else if (rise) state_nxt = HIGH;
            end
            default:   state_nxt = SYNC;
        endcase
    end

    // FSM outputs: control strobes for the counters, divider and error flags.
    always_comb begin
        hcnt_clr  = rise && (state == WAIT_RISE || (state == LOW && !timeout));
        hcnt_run  = (state == HIGH);
        meas_done = (state == HIGH) && fall && !timeout;
        prd_chk   = (state == LOW) && rise && !timeout;
`ifdef PWM_TIMEOUT_EN
        lost_set  = (state == HIGH || state == LOW) && timeout;
        lost_clr  = (state == WAIT_RISE) && rise;
`endif
    end

    // High-time counter: 1 on the rise cycle, saturating while high.
    always_ff @(posedge CLK) begin
        if (RST)                          hcnt <= '0;
        else if (hcnt_clr)                hcnt <= W_BITS'(1);
        else if (hcnt_run && hcnt != W_SAT) hcnt <= hcnt + W_BITS'(1);
    end

    // Period counter: cleared on every rise, saturating otherwise.
    always_ff @(posedge CLK) begin
        if (RST)                pcnt <= '0;
        else if (rise)          pcnt <= '0;
        else if (pcnt != P_SAT) pcnt <= pcnt + P_BITS'(1);
    end

    // ---------------- conversion ----------------
    logic              range_lo, range_hi;
    logic [W_BITS-1:0] dividend;
    logic [W_BITS-1:0] wlat;
    logic              lat_lo, lat_hi;
    logic              div_busy, div_done;
    logic [W_BITS-1:0] div_quo;
    logic              restart, deliver, prd_bad;

    // Out-of-range widths still go through the divider (with a zero dividend)
    // so every measurement has the same output latency.
    always_comb begin
        range_lo = (hcnt < W_MIN);
        range_hi = (hcnt > W_MAX);
        dividend = (range_lo || range_hi) ? '0 : hcnt - W_MIN;
        prd_bad  = (pcnt < P_LO) || (pcnt >= P_MAX);
        restart  = meas_done && div_busy;
        deliver  = div_done && !restart;
    end

    // Capture the finished measurement for the divider run.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wlat   <= '0;
            lat_lo <= 1'b0;
            lat_hi <= 1'b0;
        end else if (meas_done) begin
            wlat   <= hcnt;
            lat_lo <= range_lo;
            lat_hi <= range_hi;
        end
    end

    servo_pos_divider #(
        .DIVISOR (STEP)
    ) u_div (
        .clk      (CLK),
        .rst      (RST),
        .start    (meas_done),
        .dividend (dividend),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    // Result registers and 1-cycle strobes; a fall arriving mid-division
    // drops the pending result in favour of the new one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            POS        <= '0;
            POS_valid  <= 1'b0;
            width      <= '0;
            err_range  <= 1'b0;
            err_period <= 1'b0;
        end else begin
            POS_valid  <= 1'b0;
            err_range  <= 1'b0;
            err_period <= prd_chk && prd_bad;
            if (deliver) begin
                POS_valid <= 1'b1;
                width     <= wlat;
                POS       <= lat_hi ? POS_LIM : clamp_pos(div_quo, POS_LIM);
                err_range <= lat_lo || lat_hi;
            end
        end
    end

`ifdef PWM_TIMEOUT_EN
    // Loss-of-signal level: set on timeout, cleared by the next accepted rise.
    always_ff @(posedge CLK) begin
        if (RST)           signal_lost <= 1'b0;
        else if (lost_set) signal_lost <= 1'b1;
        else if (lost_clr) signal_lost <= 1'b0;
    end
`else
    assign signal_lost = 1'b0;
`endif

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Bench for servo_pwm_capture with scaled-down timing parameters.
// Stimulus pushes expected results into queues; a negedge monitor pops and
// compares whenever the DUT strobes POS_valid or err_period.
// Honours PWM_TIMEOUT_EN the same way as the design.
module tb_servo_pwm_capture;

    logic        CLK = 1'b0;
    logic        RST;
    logic        PWM_in;
    logic [7:0]  POS;
    logic        POS_valid;
    logic [16:0] width;
    logic        err_range;
    logic        err_period;
    logic        signal_lost;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit run    = 1'b0;

    typedef struct {
        int cyc;
        int pos;
        int wid;
        bit rng;
    } exp_t;

    exp_t exp_q[$];
    int   perr_q[$];
    exp_t e;

    servo_pwm_capture #(
        .PULSE_MIN  (200),
        .PULSE_MAX  (560),
        .STEP       (2),
        .POS_MAX    (180),
        .PERIOD_MIN (1800),
        .PERIOD_MAX (2200)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .PWM_in      (PWM_in),
        .POS         (POS),
        .POS_valid   (POS_valid),
        .width       (width),
        .err_range   (err_range),
        .err_period  (err_period),
        .signal_lost (signal_lost)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every output strobe against the scoreboard.
    always @(negedge CLK) begin
        if (run && !RST) begin
            if (POS_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pos_valid: got pos %0d width %0d, expected none (cycle %0d)",
                             POS, width, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pos_valid_cycle", cyc, e.cyc);
                    chk("pos", POS, e.pos);
                    chk("width", width, e.wid);
                    chk("err_range", err_range, e.rng);
                end
            end else if (err_range) begin
                checks++;
                errors++;
                $display("FAIL err_range_without_valid: got 1 expected 0 (cycle %0d)", cyc);
            end
            if (err_period) begin
                if (perr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_err_period: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    chk("err_period_cycle", cyc, perr_q.pop_front());
                end
            end
        end
    end

    // One pulse: rise, `high` cycles high, next rise `period` cycles after this one.
    // Result visible 20 cycles after the falling pin edge (2 sync + edge + 17 div).
    task automatic pulse(input int high, input int period, input int pos,
                         input bit rng, input bit perr, input bit drop);
        exp_t x;
        @(negedge CLK);
        PWM_in = 1'b1;
        if (perr) perr_q.push_back(cyc + 3);
        repeat (high) @(negedge CLK);
        PWM_in = 1'b0;
        if (!drop) begin
            x.cyc = cyc + 20;
            x.pos = pos;
            x.wid = high;
            x.rng = rng;
            exp_q.push_back(x);
        end
        repeat (period - high - 1) @(negedge CLK);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_pos"},         POS,         0);
        chk({tag, "_pos_valid"},   POS_valid,   0);
        chk({tag, "_width"},       width,       0);
        chk({tag, "_err_range"},   err_range,   0);
        chk({tag, "_err_period"},  err_period,  0);
        chk({tag, "_signal_lost"}, signal_lost, 0);
    endtask

    initial begin
        RST    = 1'b1;
        PWM_in = 1'b0;
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        chk_outputs_zero("reset");
        run = 1'b1;
        repeat (10) @(negedge CLK);

        //     high period pos rng perr drop
        pulse(380, 2000,  90, 0, 0, 0);   // steady state, first rise unchecked
        pulse(380, 2000,  90, 0, 0, 0);
        pulse(380, 2000,  90, 0, 0, 0);
        pulse(200, 2000,   0, 0, 0, 0);   // lower endpoint
        pulse(560, 2000, 180, 0, 0, 0);   // upper endpoint
        pulse(150, 2000,   0, 1, 0, 0);   // too short
        pulse(700, 2000, 180, 1, 0, 0);   // too long
        pulse(291, 2000,  45, 0, 0, 0);   // truncating division
        pulse(199, 2000,   0, 1, 0, 0);   // just below range
        pulse(561, 2000, 180, 1, 0, 0);   // just above range
        pulse(380, 1000,  90, 0, 0, 0);   // short period follows
        pulse(380, 1800,  90, 0, 1, 0);   // flagged (1000), period exactly min
        pulse(380, 1799,  90, 0, 0, 0);   // min accepted
        pulse(380,  383,  90, 0, 1, 1);   // 1799 flagged; result dropped by restart
        pulse( 10, 1617,   0, 1, 1, 0);   // 383 flagged; short pulse restarts divider
        pulse(380, 2000,  90, 0, 1, 0);   // 1617 flagged
`ifndef PWM_TIMEOUT_EN
        pulse(380, 2200,  90, 0, 0, 0);   // period exactly max follows
        pulse(380, 2500,  90, 0, 0, 0);   // 2200 accepted
        pulse(380, 2201,  90, 0, 1, 0);   // 2500 flagged
        pulse(380, 2000,  90, 0, 1, 0);   // 2201 flagged
`endif

        // Reset in the middle of a high phase; the rest of that pulse is ignored.
        @(negedge CLK);
        PWM_in = 1'b1;
        repeat (300) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        chk_outputs_zero("mid_reset");
        repeat (300) @(negedge CLK);
        PWM_in = 1'b0;
        repeat (1700) @(negedge CLK);
        pulse(290, 2000, 45, 0, 0, 0);

        // Input held low well beyond the longest period.
        repeat (1000) @(negedge CLK);
`ifdef PWM_TIMEOUT_EN
        chk("timeout_signal_lost", signal_lost, 1);
        chk("timeout_pos_held", POS, 45);
        pulse(380, 2000, 90, 0, 0, 0);    // resynchronised: first rise unchecked
`else
        chk("no_timeout_signal_lost", signal_lost, 0);
        pulse(380, 2000, 90, 0, 1, 0);    // 3000-cycle period flagged
`endif
        chk("recovered_signal_lost", signal_lost, 0);

        repeat (100) @(negedge CLK);
        chk("pending_results", exp_q.size(), 0);
        chk("pending_err_period", perr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
